// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-class codes, ALU control encodings and FSM states.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_MUL  = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_MUL   = 2'b10,
        S_DONE  = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of ALUOp/funct3/funct7 into an ALU control code.
module alu_decoder
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output alu_ctrl_e  alu_ctrl_c,
    output logic       illegal_c
);

    always_comb begin
        alu_ctrl_c = ALU_ADD;
        illegal_c  = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_ctrl_c = ALU_ADD;
            ALUOP_SUB: alu_ctrl_c = ALU_SUB;
            ALUOP_R: begin
                if (func7 == F7_BASE) begin
                    case (func3)
                        3'b000:  alu_ctrl_c = ALU_ADD;
                        3'b001:  alu_ctrl_c = ALU_SLL;
                        3'b010:  alu_ctrl_c = ALU_SLT;
                        3'b011:  alu_ctrl_c = ALU_SLTU;
                        3'b100:  alu_ctrl_c = ALU_XOR;
                        3'b101:  alu_ctrl_c = ALU_SRL;
                        3'b110:  alu_ctrl_c = ALU_OR;
                        default: alu_ctrl_c = ALU_AND;
                    endcase
                end else if (func7 == F7_ALT && func3 == 3'b000) begin
                    alu_ctrl_c = ALU_SUB;
                end else if (func7 == F7_ALT && func3 == 3'b101) begin
                    alu_ctrl_c = ALU_SRA;
                end else if (MUL_EN && func7 == F7_MUL && func3 == 3'b000) begin
                    alu_ctrl_c = ALU_MUL;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            default: begin
                case (func3)
                    3'b000: alu_ctrl_c = ALU_ADD;
                    3'b010: alu_ctrl_c = ALU_SLT;
                    3'b011: alu_ctrl_c = ALU_SLTU;
                    3'b100: alu_ctrl_c = ALU_XOR;
                    3'b110: alu_ctrl_c = ALU_OR;
                    3'b111: alu_ctrl_c = ALU_AND;
                    3'b001: begin
                        if (func7 == F7_BASE) alu_ctrl_c = ALU_SLL;
                        else                  illegal_c  = 1'b1;
                    end
                    default: begin
                        if      (func7 == F7_BASE) alu_ctrl_c = ALU_SRL;
                        else if (func7 == F7_ALT)  alu_ctrl_c = ALU_SRA;
                        else                       illegal_c  = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic ops, bit-serial shifts and shift-add multiply
// behind a valid/ready request and result handshake.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SW = $clog2(XLEN);

    alu_state_e      state, state_next;
    alu_ctrl_e       dec_op, op_q;
    logic            dec_illegal;
    logic [XLEN-1:0] a_q, b_q, acc_q;
    logic [SW-1:0]   cnt_q;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] basic_c, shift_c, mul_c, res_c;

    alu_decoder #(.MUL_EN(MUL_EN)) u_dec (
        .alu_op     (ALUOp),
        .func3      (func3),
        .func7      (func7),
        .alu_ctrl_c (dec_op),
        .illegal_c  (dec_illegal)
    );

    assign shamt    = b[SW-1:0];
    assign in_ready = (state == S_IDLE) && !rst;

    // Single-cycle operations evaluated straight from the request operands.
    always_comb begin
        basic_c = '0;
        case (dec_op)
            ALU_ADD:  basic_c = a + b;
            ALU_SUB:  basic_c = a - b;
            ALU_AND:  basic_c = a & b;
            ALU_OR:   basic_c = a | b;
            ALU_XOR:  basic_c = a ^ b;
            ALU_SLT:  basic_c = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: basic_c = XLEN'(a < b);
            default:  basic_c = '0;
        endcase
    end

    // One step of the serial shifter and of the shift-add multiplier.
    always_comb begin
        shift_c = a_q;
        case (op_q)
            ALU_SLL: shift_c = a_q << 1;
            ALU_SRL: shift_c = a_q >> 1;
            ALU_SRA: shift_c = {a_q[XLEN-1], a_q[XLEN-1:1]};
            default: shift_c = a_q;
        endcase
    end

    assign mul_c = acc_q + (b_q[0] ? a_q : '0);

    // Next state and the value captured into result on entry to DONE.
    always_comb begin
        state_next = state;
        res_c      = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (dec_illegal) begin
                        state_next = S_DONE;
                    end else if (dec_op == ALU_SLL || dec_op == ALU_SRL || dec_op == ALU_SRA) begin
                        res_c      = a;
                        state_next = (shamt == '0) ? S_DONE : S_SHIFT;
                    end else if (dec_op == ALU_MUL) begin
                        state_next = S_MUL;
                    end else begin
                        res_c      = basic_c;
                        state_next = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                res_c = shift_c;
                if (cnt_q == '0) state_next = S_DONE;
            end
            S_MUL: begin
                res_c = mul_c;
                if (cnt_q == '0) state_next = S_DONE;
            end
            default: begin
                if (out_ready) state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= dec_op;
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= '0;
                        cnt_q <= (dec_op == ALU_MUL) ? SW'(XLEN - 1) : shamt - SW'(1);
                    end
                end
                S_SHIFT: begin
                    a_q   <= shift_c;
                    cnt_q <= cnt_q - SW'(1);
                end
                S_MUL: begin
                    acc_q <= mul_c;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - SW'(1);
                end
                default: ;
            endcase
            if (state != S_DONE && state_next == S_DONE) begin
                result  <= res_c;
                zero    <= (res_c == '0);
                illegal <= (state == S_IDLE) && dec_illegal;
            end
        end
    end

endmodule
